// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// word geometry and a small byte-counter helper.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;   // bytes per instruction word
  localparam int ADDR_LSB   = 2;   // byte-address bits below the word index
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  // True when the byte counter points at the final byte of a word
  function automatic logic is_last_byte(input logic [1:0] cnt);
    return cnt == 2'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// 8->32 packing register. Each loaded byte shifts the word by one lane so
// that after four loads the first byte sits in [31:24] (BIG_ENDIAN=1) or in
// [7:0] (BIG_ENDIAN=0). word_next_o shows the word including the byte being
// offered this cycle, so the caller can capture a complete word on the same
// edge that accepts its last byte.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_next_o
);

  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_next;

  // Per-lane shift network: each lane takes its neighbour, the entry lane takes byte_i
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    if (BIG_ENDIAN) begin : g_be
      if (gi == 0) begin : g_entry
        assign word_next[gi*BYTE_W +: BYTE_W] = byte_i;
      end else begin : g_shift
        assign word_next[gi*BYTE_W +: BYTE_W] = word_reg[(gi-1)*BYTE_W +: BYTE_W];
      end
    end else begin : g_le
      if (gi == WORD_BYTES - 1) begin : g_entry
        assign word_next[gi*BYTE_W +: BYTE_W] = byte_i;
      end else begin : g_shift
        assign word_next[gi*BYTE_W +: BYTE_W] = word_reg[(gi+1)*BYTE_W +: BYTE_W];
      end
    end
  end

  assign word_next_o = word_next;

  // Packing register: cleared on reset or new load/abort, shifts on each accepted byte
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_reg <= '0;
    end else if (load_i) begin
      word_reg <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream over valid/ready, packs
// four bytes per word and writes words to consecutive word-aligned byte
// addresses from 0. The CPU is held in reset until a complete image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              abort_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Largest legal length: the full memory capacity
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t              state_reg;
  logic [1:0]          byte_cnt_reg;
  logic [ADDR_W-1:0]   word_cnt_reg;
  logic [ADDR_W:0]     len_reg;

  logic                byte_ready_reg;
  logic                mem_we_reg;
  logic [31:0]         mem_addr_reg;
  logic [31:0]         mem_data_reg;
  logic                cpu_rst_n_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;

  logic                byte_fire;
  logic                start_accept;
  logic                abort_hit;
  logic                last_word;
  logic                packer_load;
  logic                packer_clr;
  logic [WORD_W-1:0]   packed_next;
  logic [31:0]         word_addr;

  // Handshake, start/abort qualification and word-position decode
  always_comb begin
    byte_fire    = byte_valid_i & byte_ready_reg;
    start_accept = start_i & ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    abort_hit    = abort_i & ((state_reg == ST_RECV) || (state_reg == ST_WRITE));
    last_word    = ({1'b0, word_cnt_reg} == (len_reg - LEN_ONE));
    // An abort on the same edge as a byte discards that byte too
    packer_load  = byte_fire & (state_reg == ST_RECV) & ~abort_i;
    packer_clr   = start_accept | abort_hit;
    word_addr    = {{(32-ADDR_W-ADDR_LSB){1'b0}}, word_cnt_reg, {ADDR_LSB{1'b0}}};
  end

  imem_byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (packer_clr),
    .load_i      (packer_load),
    .byte_i      (byte_i),
    .word_next_o (packed_next)
  );

  // Loader FSM with counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      byte_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
      len_reg        <= '0;
      byte_ready_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      cpu_rst_n_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse
      mem_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // abort_i is meaningless here, so start always wins
          if (start_i) begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cpu_rst_n_reg <= 1'b0;
            byte_cnt_reg  <= '0;
            word_cnt_reg  <= '0;
            if (len_i == '0) begin
              // Empty image: nothing to write, release the CPU at once
              state_reg     <= ST_DONE;
              done_reg      <= 1'b1;
              cpu_rst_n_reg <= 1'b1;
            end else if (len_i > MAX_LEN) begin
              state_reg <= ST_IDLE;
              err_reg   <= 1'b1;
            end else begin
              len_reg        <= len_i;
              state_reg      <= ST_RECV;
              byte_ready_reg <= 1'b1;
              busy_reg       <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (abort_i) begin
            // Abort sampled with a word's last byte also cancels its write
            state_reg      <= ST_IDLE;
            err_reg        <= 1'b1;
            byte_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            byte_cnt_reg   <= '0;
          end else if (byte_fire) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (is_last_byte(byte_cnt_reg)) begin
              // Word complete: present it to memory in the next cycle
              state_reg      <= ST_WRITE;
              byte_ready_reg <= 1'b0;
              mem_we_reg     <= 1'b1;
              mem_addr_reg   <= word_addr;
              mem_data_reg   <= packed_next;
            end
          end
        end

        ST_WRITE: begin
          if (abort_i) begin
            state_reg      <= ST_IDLE;
            err_reg        <= 1'b1;
            byte_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            byte_cnt_reg   <= '0;
          end else if (last_word) begin
            state_reg     <= ST_DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            cpu_rst_n_reg <= 1'b1;
          end else begin
            word_cnt_reg   <= word_cnt_reg + ADDR_W'(1);
            state_reg      <= ST_RECV;
            byte_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          byte_ready_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = byte_ready_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_data_o   = mem_data_reg;
  assign cpu_rst_n_o  = cpu_rst_n_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one big-endian and one little-endian
// instance share the same stimulus; a negedge monitor records writes.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;

  logic              ready_be, we_be, cpu_be, busy_be, done_be, err_be;
  logic [31:0]       addr_be, data_be;
  logic              ready_le, we_le, cpu_le, busy_le, done_le, err_le;
  logic [31:0]       addr_le, data_le;

  imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) u_be (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .abort_i(abort),
    .byte_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(ready_be),
    .mem_we_o(we_be), .mem_addr_o(addr_be), .mem_data_o(data_be),
    .cpu_rst_n_o(cpu_be), .busy_o(busy_be), .done_o(done_be), .err_o(err_be)
  );

  imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) u_le (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .abort_i(abort),
    .byte_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(ready_le),
    .mem_we_o(we_le), .mem_addr_o(addr_le), .mem_data_o(data_le),
    .cpu_rst_n_o(cpu_le), .busy_o(busy_le), .done_o(done_le), .err_o(err_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Write model: sole writer of these variables is the monitor below
  logic [31:0] mem_be [DEPTH];
  logic [31:0] mem_le [DEPTH];
  int          wr_total_be = 0;
  int          wr_total_le = 0;
  logic [31:0] last_addr_be = '0;

  always @(negedge clk) begin
    if (we_be) begin
      wr_total_be  = wr_total_be + 1;
      mem_be[addr_be[ADDR_W+1:2]] = data_be;
      last_addr_be = addr_be;
      if (verbose) $display("write be: addr=0x%08h data=0x%08h", addr_be, data_be);
    end
    if (we_le) begin
      wr_total_le = wr_total_le + 1;
      mem_le[addr_le[ADDR_W+1:2]] = data_le;
      if (verbose) $display("write le: addr=0x%08h data=0x%08h", addr_le, data_le);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Status vector {ready, busy, done, err, cpu_rst_n} of the big-endian DUT
  function automatic logic [31:0] status_be();
    return {27'b0, ready_be, busy_be, done_be, err_be, cpu_be};
  endfunction

  // Offer one byte, wait (bounded) for the handshake; returns at the negedge after it
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!ready_be && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("ready_timeout", 32'(t), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  // Stream order is always most-significant byte of w first
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic start_load(input logic [ADDR_W:0] n, input bit with_abort);
    start = 1'b1;
    len   = n;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done_be && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_wait", {31'b0, done_be}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_status"}, status_be(), 32'h0);
    check_eq({tag, "_we"}, {31'b0, we_be}, 32'd0);
    check_eq({tag, "_addr"}, addr_be, 32'h0);
    check_eq({tag, "_data"}, data_be, 32'h0);
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // len=2 image: both endian orders from one stream
    base = wr_total_be;
    start_load(11'd2, 1'b0);
    check_eq("t1_recv_status", status_be(), 32'h18);
    send_word(32'h20080005, 1'b0);
    check_eq("t1_we_latency", {31'b0, we_be}, 32'd1);
    check_eq("t1_addr0", addr_be, 32'h0);
    send_word(32'h20090007, 1'b0);
    wait_done();
    check_eq("t1_be_w0", mem_be[0], 32'h20080005);
    check_eq("t1_be_w1", mem_be[1], 32'h20090007);
    check_eq("t1_le_w0", mem_le[0], 32'h05000820);
    check_eq("t1_le_w1", mem_le[1], 32'h07000920);
    check_eq("t1_last_addr", last_addr_be, 32'h4);
    check_eq("t1_writes", 32'(wr_total_be - base), 32'd2);
    check_eq("t1_done_status", status_be(), 32'h5);
    check_eq("t1_le_status", {27'b0, ready_le, busy_le, done_le, err_le, cpu_le}, 32'h5);

    // len=3 with valid toggled every other cycle
    base = wr_total_be;
    start_load(11'd3, 1'b0);
    check_eq("t2_restart_status", status_be(), 32'h18);
    send_word(32'h11223344, 1'b1);
    send_word(32'h55667788, 1'b1);
    send_word(32'h99AABBCC, 1'b1);
    wait_done();
    check_eq("t2_be_w0", mem_be[0], 32'h11223344);
    check_eq("t2_be_w1", mem_be[1], 32'h55667788);
    check_eq("t2_be_w2", mem_be[2], 32'h99AABBCC);
    check_eq("t2_le_w2", mem_le[2], 32'hCCBBAA99);
    check_eq("t2_writes", 32'(wr_total_be - base), 32'd3);
    check_eq("t2_le_writes", 32'(wr_total_le - base), 32'd3);

    // len=0: straight to DONE, no writes
    base = wr_total_be;
    start_load(11'd0, 1'b0);
    check_eq("t3_len0_status", status_be(), 32'h5);
    @(negedge clk);
    check_eq("t3_writes", 32'(wr_total_be - base), 32'd0);

    // len above capacity: error, CPU back in reset
    start_load(11'(DEPTH + 1), 1'b0);
    check_eq("t4_badlen_status", status_be(), 32'h2);
    @(negedge clk);
    check_eq("t4_stay_idle", status_be(), 32'h2);

    // Abort after 6 bytes of len=4
    base = wr_total_be;
    start_load(11'd4, 1'b0);
    send_word(32'hA1A2A3A4, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_abort_status", status_be(), 32'h2);
    check_eq("t5_writes", 32'(wr_total_be - base), 32'd1);
    check_eq("t5_w0", mem_be[0], 32'hA1A2A3A4);
    // abort outside a load is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_idle_abort", status_be(), 32'h2);

    // Restart len=1 with start and abort together in IDLE: start wins
    base = wr_total_be;
    start_load(11'd1, 1'b1);
    check_eq("t6_start_wins", status_be(), 32'h18);
    send_word(32'hDEADBEEF, 1'b0);
    wait_done();
    check_eq("t6_w0", mem_be[0], 32'hDEADBEEF);
    check_eq("t6_w1_untouched", mem_be[1], 32'hA1A2A3A4 & 32'h0 | 32'h55667788);
    check_eq("t6_writes", 32'(wr_total_be - base), 32'd1);
    check_eq("t6_status", status_be(), 32'h5);

    // Full-capacity load: last address at the top, no word-counter wrap
    verbose = 1'b0;
    base = wr_total_be;
    start_load(11'(DEPTH), 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word(32'hC0DE0000 | 32'(i), 1'b0);
    wait_done();
    verbose = 1'b1;
    $display("full load: %0d words", wr_total_be - base);
    check_eq("t7_writes", 32'(wr_total_be - base), 32'(DEPTH));
    check_eq("t7_last_addr", last_addr_be, 32'((DEPTH - 1) << 2));
    check_eq("t7_first", mem_be[0], 32'hC0DE0000);
    check_eq("t7_last", mem_be[DEPTH-1], 32'hC0DE0000 | 32'(DEPTH - 1));
    check_eq("t7_status", status_be(), 32'h5);

    // Reset in the middle of a load
    start_load(11'd4, 1'b0);
    send_word(32'h01020304, 1'b0);
    send_byte(8'h05, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t8_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
